// File: rtl/cache_miss_ctrl_pkg.sv
// Shared definitions for the cache miss controller: default geometry,
// FSM state encoding and the latched CPU request record.
package cache_miss_ctrl_pkg;

  localparam int OFFSET_W_DEF = 3;
  localparam int INDEX_W_DEF  = 6;
  localparam int TAG_W_DEF    = 30 - OFFSET_W_DEF - INDEX_W_DEF;
  localparam int BLK_W_DEF    = 32 * (2 ** OFFSET_W_DEF);

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOOKUP = 3'd1;
  localparam logic [STATE_W-1:0] ST_RESP   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WB     = 3'd3;
  localparam logic [STATE_W-1:0] ST_FILL   = 3'd4;
  localparam logic [STATE_W-1:0] ST_REFILL = 3'd5;

  // CPU request as captured on accept; held for the whole transaction.
  typedef struct packed {
    logic        we;
    logic [3:0]  byte_w_en;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cpu_req_t;

endpackage

// File: rtl/cache_miss_ctrl_if.sv
// CPU-side and memory-side handshake bundles of the cache miss controller.
// master = initiator of the request, slave = responder.
interface cache_cpu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  byte_w_en;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, byte_w_en, wdata, input ready, rdata);
  modport slave  (input req, we, addr, byte_w_en, wdata, output ready, rdata);
endinterface

interface cache_mem_if
  import cache_miss_ctrl_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF
);
  logic             req;
  logic             we;
  logic [31:0]      addr;
  logic [BLK_W-1:0] wdata;
  logic             ready;
  logic [BLK_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/cache_miss_ctrl_sat_counter.sv
// Saturating up-counter: stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count increment requests until the counter is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss controller for a 2-way write-back cache: looks up the array, writes
// back a dirty victim, fetches the missing block, refills and retries.
module cache_miss_ctrl
  import cache_miss_ctrl_pkg::*;
#(
  parameter int  OFFSET_WIDTH = OFFSET_W_DEF,
  parameter int  INDEX_WIDTH  = INDEX_W_DEF,
  parameter int  TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
  localparam int BLK_W        = 32 * (2 ** OFFSET_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_cpu_if.slave              cpu,
  cache_mem_if.master             mem,
  output logic                    o_c_enable,
  output logic                    o_c_cmp,
  output logic                    o_c_write,
  output logic                    o_c_valid_in,
  output logic [3:0]              o_c_byte_w_en,
  output logic [TAG_WIDTH-1:0]    o_c_tag,
  output logic [INDEX_WIDTH-1:0]  o_c_index,
  output logic [OFFSET_WIDTH-1:0] o_c_word_sel,
  output logic [31:0]             o_c_data_in,
  output logic [BLK_W-1:0]        o_c_block_in,
  input  logic                    i_c_hit,
  input  logic                    i_c_dirty,
  input  logic [TAG_WIDTH-1:0]    i_c_tag_out,
  input  logic [31:0]             i_c_data_out,
  input  logic [BLK_W-1:0]        i_c_data_wb,
  output logic [31:0]             o_miss_cnt
);

  logic [STATE_W-1:0]     r_state;
  logic [STATE_W-1:0]     w_state_next;
  cpu_req_t               r_req;
  logic [31:0]            r_rdata;
  logic                   r_wb_first;
  logic [TAG_WIDTH-1:0]   r_wb_tag;
  logic [BLK_W-1:0]       r_wb_buf;
  logic [BLK_W-1:0]       r_fill_buf;

  logic [TAG_WIDTH-1:0]   w_tag;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [TAG_WIDTH-1:0]   w_wb_tag;
  logic [BLK_W-1:0]       w_wb_data;
  logic                   w_miss_inc;

  assign w_tag   = r_req.addr[31 -: TAG_WIDTH];
  assign w_index = r_req.addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];

  // The victim is only registered at the end of the first WB cycle, so that
  // cycle forwards the array outputs straight to memory.
  assign w_wb_tag  = r_wb_first ? i_c_tag_out : r_wb_tag;
  assign w_wb_data = r_wb_first ? i_c_data_wb : r_wb_buf;

  assign w_miss_inc = (r_state == ST_LOOKUP) && !i_c_hit;

  // Next-state decode; mem.ready only matters while waiting in WB or FILL.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (cpu.req) w_state_next = ST_LOOKUP;
      ST_LOOKUP: begin
        if (i_c_hit)        w_state_next = ST_RESP;
        else if (i_c_dirty) w_state_next = ST_WB;
        else                w_state_next = ST_FILL;
      end
      ST_RESP:   w_state_next = ST_IDLE;
      ST_WB:     if (mem.ready) w_state_next = ST_FILL;
      ST_FILL:   if (mem.ready) w_state_next = ST_REFILL;
      ST_REFILL: w_state_next = ST_LOOKUP;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Capture the request on accept; later cpu.* changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '0;
    end else if ((r_state == ST_IDLE) && cpu.req) begin
      r_req <= '{we: cpu.we, byte_w_en: cpu.byte_w_en, addr: cpu.addr, wdata: cpu.wdata};
    end
  end

  // Load data is taken from the array on the hitting lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_rdata <= '0;
    else if ((r_state == ST_LOOKUP) && i_c_hit) r_rdata <= i_c_data_out;
  end

  // Victim write-back buffer, loaded in the first WB cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_first <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_buf   <= '0;
    end else begin
      r_wb_first <= (r_state == ST_LOOKUP) && !i_c_hit && i_c_dirty;
      if (r_wb_first) begin
        r_wb_tag <= i_c_tag_out;
        r_wb_buf <= i_c_data_wb;
      end
    end
  end

  // Fill buffer holds the fetched block for the refill write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     r_fill_buf <= '0;
    else if ((r_state == ST_FILL) && mem.ready)  r_fill_buf <= mem.rdata;
  end

  // Strobes and bus fields decoded from the current state.
  always_comb begin
    o_c_enable   = 1'b0;
    o_c_cmp      = 1'b0;
    o_c_write    = 1'b0;
    o_c_valid_in = 1'b0;
    cpu.ready    = 1'b0;
    mem.req      = 1'b0;
    mem.we       = 1'b0;
    mem.addr     = '0;
    mem.wdata    = '0;
    case (r_state)
      ST_LOOKUP: begin
        o_c_enable = 1'b1;
        o_c_cmp    = 1'b1;
        o_c_write  = r_req.we;
      end
      ST_RESP: cpu.ready = 1'b1;
      ST_WB: begin
        o_c_enable = 1'b1;
        mem.req    = 1'b1;
        mem.we     = 1'b1;
        mem.addr   = {w_wb_tag, w_index, {(OFFSET_WIDTH+2){1'b0}}};
        mem.wdata  = w_wb_data;
      end
      ST_FILL: begin
        mem.req  = 1'b1;
        mem.addr = {w_tag, w_index, {(OFFSET_WIDTH+2){1'b0}}};
      end
      ST_REFILL: begin
        o_c_enable   = 1'b1;
        o_c_write    = 1'b1;
        o_c_valid_in = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_c_byte_w_en = r_req.byte_w_en;
  assign o_c_tag       = w_tag;
  assign o_c_index     = w_index;
  assign o_c_word_sel  = r_req.addr[2 +: OFFSET_WIDTH];
  assign o_c_data_in   = r_req.wdata;
  assign o_c_block_in  = r_fill_buf;
  assign cpu.rdata     = r_rdata;

  sat_counter #(.WIDTH(32)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_miss_inc),
    .o_count (o_miss_cnt)
  );

endmodule
